// File: rtl/prefix_add_arbiter_pkg.sv
// Shared types and constants for the prefix-adder arbiter slice.
// Holds the default operand width, the FSM state encoding and the id-width helper.
package prefix_add_arbiter_pkg;

  localparam int INPUTSIZE = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Requester id width; a single requester still gets one bit so ports never collapse.
  function automatic int id_width(input int nreq);
    return (nreq < 2) ? 1 : $clog2(nreq);
  endfunction

endpackage

// File: rtl/prefix_add_arbiter_if.sv
// Requester/consumer side of the shared adder: request bundle in, response bundle out.
// The master is the requester/consumer side; the slave is the arbiter.
interface prefix_add_arbiter_if
  import prefix_add_arbiter_pkg::*;
#(
  parameter int WIDTH = INPUTSIZE,
  parameter int NREQ  = 2,
  localparam int IDW  = id_width(NREQ)
);

  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic [NREQ-1:0]       req_cin;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [WIDTH-1:0]      rsp_sum;
  logic                  rsp_cout;
  logic [IDW-1:0]        rsp_id;

  modport master (
    output req_valid, req_a, req_b, req_cin, rsp_ready,
    input  req_ready, rsp_valid, rsp_sum, rsp_cout, rsp_id
  );

  modport slave (
    input  req_valid, req_a, req_b, req_cin, rsp_ready,
    output req_ready, rsp_valid, rsp_sum, rsp_cout, rsp_id
  );

endinterface

// File: rtl/prefix_add_arbiter_rr.sv
// Round-robin arbiter: grants the first valid requester after the last winner.
// The pointer only moves when the parent reports an accept through advance.
module rr_arbiter
  import prefix_add_arbiter_pkg::*;
#(
  parameter int NREQ = 2,
  localparam int IDW = id_width(NREQ)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  input  logic            advance,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  grant_id
);

  logic [IDW-1:0] ptr_q;
  logic [IDW-1:0] idx;
  logic           found;

  // NOTE: every variable gets a default before the loop so no path leaves it unassigned (no latch).
  always_comb begin
    grant    = '0;
    grant_id = '0;
    idx      = '0;
    found    = 1'b0;
    for (int i = 1; i <= NREQ; i++) begin
      idx = IDW'((int'(ptr_q) + i) % NREQ);
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_id   = idx;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q <= IDW'(NREQ - 1);
    end else if (advance) begin
      ptr_q <= grant_id;
    end
  end

endmodule

// File: rtl/prefix_add_arbiter.sv
// Time-shares one external parallel-prefix adder between NREQ requesters.
// Operands are registered toward the adder, and the sum is registered toward the consumer.
module prefix_add_arbiter
  import prefix_add_arbiter_pkg::*;
#(
  parameter int WIDTH = INPUTSIZE,
  parameter int NREQ  = 2,
  localparam int IDW  = id_width(NREQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  prefix_add_arbiter_if.slave bus,
  output logic [WIDTH-1:0]   add_a,
  output logic [WIDTH-1:0]   add_b,
  output logic               add_cin,
  input  logic [WIDTH-1:0]   add_sum,
  input  logic               add_cout
);

  state_e           state_q, state_d;
  logic [NREQ-1:0]  grant;
  logic [IDW-1:0]   grant_id;
  logic             can_accept;
  logic             accept;

  logic [WIDTH-1:0] sel_a, sel_b;
  logic             sel_cin;

  logic [IDW-1:0]   id_q;
  logic [WIDTH-1:0] rsp_sum_q;
  logic             rsp_cout_q;
  logic [IDW-1:0]   rsp_id_q;

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (bus.req_valid),
    .advance  (accept),
    .grant    (grant),
    .grant_id (grant_id)
  );

  // A new operation may enter when the adder slot is free or the held result leaves this cycle.
  assign can_accept    = (state_q == ST_IDLE) || ((state_q == ST_RESP) && bus.rsp_ready);
  assign bus.req_ready = can_accept ? grant : '0;
  assign accept        = |bus.req_ready;

  // One-hot AND-OR select: an ungranted requester's operands never reach the adder registers.
  always_comb begin
    sel_a   = '0;
    sel_b   = '0;
    sel_cin = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (grant[k]) begin
        sel_a   = bus.req_a[k*WIDTH +: WIDTH];
        sel_b   = bus.req_b[k*WIDTH +: WIDTH];
        sel_cin = bus.req_cin[k];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (accept) state_d = ST_CALC;
      ST_CALC: state_d = ST_RESP;
      ST_RESP: if (bus.rsp_ready) state_d = accept ? ST_CALC : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      add_a      <= '0;
      add_b      <= '0;
      add_cin    <= 1'b0;
      id_q       <= '0;
      rsp_sum_q  <= '0;
      rsp_cout_q <= 1'b0;
      rsp_id_q   <= '0;
    end else begin
      if (accept) begin
        add_a   <= sel_a;
        add_b   <= sel_b;
        add_cin <= sel_cin;
        id_q    <= grant_id;
      end
      // The adder has had a full cycle to settle on the registered operands.
      if (state_q == ST_CALC) begin
        rsp_sum_q  <= add_sum;
        rsp_cout_q <= add_cout;
        rsp_id_q   <= id_q;
      end
    end
  end

  assign bus.rsp_valid = (state_q == ST_RESP);
  assign bus.rsp_sum   = rsp_sum_q;
  assign bus.rsp_cout  = rsp_cout_q;
  assign bus.rsp_id    = rsp_id_q;

endmodule
